// File: rtl/demux_stream_3way.sv
`default_nettype none
// ============================================================================
//  Module   : demux_stream_3way
//  Purpose  : Registered 1-to-3 stream demultiplexer. Accepts one word per
//             cycle on a valid/ready input and routes it by a 2-bit select to
//             one of three valid/ready output channels. The word is held until
//             the selected channel accepts it. Select 2'b11 has no target: the
//             word is accepted and discarded. A one-cycle error pulse flags
//             the discard, and a saturating counter counts it.
//  Ports    : clk        rising-edge clock
//             rst        synchronous reset, active-high
//             in_valid   input word valid
//             in_ready   input word accepted when in_valid && in_ready
//             in_sel     route: 00->ch0, 01->ch1, 10->ch2, 11->drop
//             in_data    input word
//             out_valid  one-hot, bit i = word held for channel i
//             out_ready  per-channel accept
//             out_data   held word, shared by all three channels
//             drop_err   pulse, cycle after a 2'b11 word is accepted
//             drop_cnt   saturating count of dropped words
//  Revision : 1.0  initial release
// ============================================================================
module demux_stream_3way #(
    parameter int DATA_W = 2,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_sel,
    input  logic [DATA_W-1:0] in_data,
    output logic [2:0]        out_valid,
    input  logic [2:0]        out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              drop_err,
    output logic [CNT_W-1:0]  drop_cnt
);

    localparam logic [1:0]       c_sel_drop = 2'b11;
    localparam logic [CNT_W-1:0] c_cnt_max  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_cnt_one  = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t              state_q,     state_d;
    logic [2:0]          out_valid_q, out_valid_d;
    logic [DATA_W-1:0]   out_data_q,  out_data_d;
    logic                drop_err_q,  drop_err_d;
    logic [CNT_W-1:0]    drop_cnt_q,  drop_cnt_d;

    logic w_drain;
    logic w_accept;
    logic w_routed;
    logic w_drop;

    // Only the channel that actually holds the word can drain it; ready on
    // the other two channels is masked off by the one-hot valid.
    assign w_drain  = (state_q == FULL) && (|(out_valid_q & out_ready));
    // Ready depends only on the register state and out_ready, never on
    // in_valid, so an upstream source may wait for ready before asserting.
    assign in_ready = (state_q == EMPTY) || w_drain;
    assign w_accept = in_valid && in_ready;
    assign w_routed = w_accept && (in_sel != c_sel_drop);
    assign w_drop   = w_accept && (in_sel == c_sel_drop);

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        drop_err_d  = w_drop;
        drop_cnt_d  = drop_cnt_q;

        if (w_routed) begin
            // Covers both EMPTY->FULL and the back-to-back FULL->FULL case
            // where the old word drains in the same cycle.
            state_d     = FULL;
            out_valid_d = 3'b001 << in_sel;
            out_data_d  = in_data;
        end else if (w_drain) begin
            // out_data keeps its last value; only the valid is cleared.
            state_d     = EMPTY;
            out_valid_d = 3'b000;
        end

        if (w_drop && (drop_cnt_q != c_cnt_max)) begin
            drop_cnt_d = drop_cnt_q + c_cnt_one;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= EMPTY;
            out_valid_q <= 3'b000;
            out_data_q  <= '0;
            drop_err_q  <= 1'b0;
            drop_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            drop_err_q  <= drop_err_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign drop_err  = drop_err_q;
    assign drop_cnt  = drop_cnt_q;

endmodule
`default_nettype wire
